tt_cdc_fifo: RTL and testbench

- 8-deep x 8-bit FIFO in a TinyTapeout-style user-project shell, clocked by a single system clock.
- Write and read requests arrive on asynchronous pins. Each is passed through a synchronizer and converted to a single-cycle pulse on its rising edge.
- Pushed data comes from ui_in. Popped data is presented on uo_out. Status flags drive uio_out.

---
 rtl/tt_cdc_fifo.sv | 135 +++++++++++++
 tb/tb_tt_cdc_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt_cdc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tt_cdc_fifo
// Purpose  : FIFO (DEPTH x DATA_W) in a TinyTapeout-style shell. Write and
//            read requests arrive as asynchronous levels. Each one is
//            synchronized and turned into a one-cycle pulse on its rising edge.
// Ports    : clk      - system clock, rising edge
//            rst_n    - asynchronous reset, ACTIVE-HIGH (the _n is historical)
//            ena      - pulse enable; synchronizers keep running when low
//            ui_in    - write data
//            uio_in   - [0] wr_req, [1] rd_req (async levels), [7:2] unused
//            uo_out   - last popped word (registered)
//            uio_out  - [2] full [3] empty [4] overflow [5] underflow
//                       [6] almost_full [7] almost_empty, [1:0] = 0
//            uio_oe   - constant 8'b1111_1100
// Revision : 1.0 - initial release
// ============================================================================
module tt_cdc_fifo #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 8,  // power of 2
  parameter int unsigned SYNC_STAGES = 2   // must be >= 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] ui_in,
  input  logic [7:0]        uio_in,
  output logic [DATA_W-1:0] uo_out,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);

  localparam int unsigned c_PTR_W = $clog2(DEPTH);
  localparam int unsigned c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_AF_CNT   = c_CNT_W'(DEPTH - 1);

  // Index 0 = write request, index 1 = read request.
  logic [1:0] w_pulse;

  for (genvar g = 0; g < 2; g++) begin : g_req
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_edge;

    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        r_sync <= '0;
        r_edge <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], uio_in[g]};
        r_edge <= r_sync[SYNC_STAGES-1];
      end
    end

    // A long high level gives exactly one pulse. While ena is low the pulse
    // is masked, but the edge flop still advances, so the request is lost.
    assign w_pulse[g] = r_sync[SYNC_STAGES-1] & ~r_edge & ena;
  end

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_overflow;
  logic               r_underflow;
  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full  = (r_count == c_FULL_CNT);
  assign w_empty = (r_count == '0);

  // A pop on an empty FIFO is ignored, even when a push happens in the same
  // cycle (no fall-through). A push into a full FIFO succeeds only if a pop
  // frees the slot in the same cycle.
  assign w_do_pop  = w_pulse[1] & ~w_empty;
  assign w_do_push = w_pulse[0] & (~w_full | w_do_pop);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rdata     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        // When full, rd_ptr == wr_ptr. This reads the old word while the
        // new word is written to the same slot.
        r_rdata  <= r_mem[r_rd_ptr];
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
      if (w_pulse[0] && !w_do_push) begin
        r_overflow <= 1'b1;
      end
      if (w_pulse[1] && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Storage has no reset; its contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= ui_in;
    end
  end

  assign uo_out  = r_rdata;
  assign uio_out = {(r_count <= c_CNT_W'(1)),
                    (r_count >= c_AF_CNT),
                    r_underflow,
                    r_overflow,
                    w_empty,
                    w_full,
                    2'b00};
  assign uio_oe  = 8'b1111_1100;

  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, uio_in[7:2]};

endmodule
`default_nettype wire

// File: tb/tb_tt_cdc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_cdc_fifo
// Purpose  : Self-checking bench for tt_cdc_fifo. It uses a queue-based
//            reference model and a scoreboard queue of expected outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_cdc_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_cdc_fifo #(.DATA_W(8), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [7:0] m_q[$];
  logic [7:0] m_uo;
  bit         m_ovf;
  bit         m_unf;

  typedef struct {
    logic [7:0] uo;
    logic [7:0] uio;
    string      tag;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] model_uio();
    int n = m_q.size();
    return {(n <= 1) ? 1'b1 : 1'b0, (n >= DEPTH-1) ? 1'b1 : 1'b0,
            m_unf ? 1'b1 : 1'b0, m_ovf ? 1'b1 : 1'b0,
            (n == 0) ? 1'b1 : 1'b0, (n == DEPTH) ? 1'b1 : 1'b0, 2'b00};
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_uo  = 8'h00;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  function automatic void model_apply(bit wr, bit rd, logic [7:0] d, bit en);
    int  n_before;
    bit  popped;
    if (!en) return;
    n_before = m_q.size();
    popped   = rd && (n_before > 0);
    if (popped) m_uo = m_q.pop_front();
    if (rd && n_before == 0) m_unf = 1'b1;
    if (wr) begin
      if (n_before < DEPTH || popped) m_q.push_back(d);
      else m_ovf = 1'b1;
    end
  endfunction

  function automatic void expect_now(string tag);
    exp_t e;
    e.uo  = m_uo;
    e.uio = model_uio();
    e.tag = tag;
    sb.push_back(e);
  endfunction

  // Monitor: compares pending expectations on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, ".uo_out"},  uo_out,  e.uo);
        check({e.tag, ".uio_out"}, uio_out, e.uio);
        check({e.tag, ".uio_oe"},  uio_oe,  8'hFC);
      end
    end
  end

  // One request: pins rise mid-cycle before E0. The state must be unchanged
  // after E1 and updated after E2.
  task automatic req(bit wr, bit rd, logic [7:0] d, string tag);
    @(negedge clk); #1;
    ui_in     = d;
    uio_in[0] = wr;
    uio_in[1] = rd;
    @(posedge clk);
    @(posedge clk); #1;
    expect_now({tag, ".pre"});
    @(posedge clk); #1;
    model_apply(wr, rd, d, ena);
    expect_now({tag, ".post"});
    @(negedge clk);
    uio_in[1:0] = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = {6'b101101, 2'b00};  // upper bits are don't-care junk
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    expect_now("reset_idle");

    // Single push/pop with latency check.
    req(1, 0, 8'hA5, "push_a5");
    req(0, 1, 8'h00, "pop_a5");

    // Fill, overflow, drain, underflow.
    for (int i = 1; i <= 8; i++) req(1, 0, 8'(i), "fill");
    req(1, 0, 8'hFF, "overflow");
    for (int i = 0; i < 8; i++) req(0, 1, 8'h00, "drain");
    req(0, 1, 8'h00, "underflow");

    // Pointer wrap.
    for (int i = 0; i < 5; i++) req(1, 0, 8'h30 + 8'(i), "wrap_push5");
    for (int i = 0; i < 5; i++) req(0, 1, 8'h00, "wrap_pop5");
    for (int i = 0; i < 8; i++) req(1, 0, 8'h50 + 8'(i), "wrap_push8");
    req(1, 1, 8'hC3, "full_pushpop");
    for (int i = 0; i < 8; i++) req(0, 1, 8'h00, "wrap_pop8");
    req(1, 1, 8'h77, "empty_pushpop");
    req(0, 1, 8'h00, "pop_77");

    // The enable mask drops the request.
    ena = 1'b0;
    req(1, 0, 8'h99, "ena0_push");
    ena = 1'b1;

    // A long-held request pushes exactly once.
    @(negedge clk); #1;
    ui_in = 8'h6E; uio_in[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    model_apply(1, 0, 8'h6E, 1'b1);
    repeat (20) begin
      @(posedge clk); #1;
      expect_now("hold20");
    end
    @(negedge clk); uio_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    req(0, 1, 8'h00, "pop_6e");

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      bit wr, rd;
      wr  = ($urandom_range(0, 99) < 60);
      rd  = ($urandom_range(0, 99) < 50);
      ena = ($urandom_range(0, 7) != 0);
      req(wr, rd, 8'($urandom), "rand");
    end
    ena = 1'b1;

    // Asynchronous reset mid-burst.
    model_reset();
    rst_n = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) req(1, 0, 8'hE0 + 8'(i), "pre_rst");
    req(0, 1, 8'h00, "pre_rst_pop");  // drains to 3; uo_out nonzero
    req(0, 0, 8'h00, "idle");
    req(1, 0, 8'hEE, "pre_rst4");
    req(0, 0, 8'h00, "settle");
    @(negedge clk); #1;
    ui_in = 8'h44; uio_in[1:0] = 2'b11;
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    check("async_rst.uo_out",  uo_out,  8'h00);
    check("async_rst.uio_out", uio_out, 8'h88);
    model_reset();
    uio_in[1:0] = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    expect_now("post_rst_idle");
    req(1, 0, 8'h3C, "post_rst_push");
    req(0, 1, 8'h00, "post_rst_pop");

    repeat (4) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
